rx_fifo: RTL and testbench

RX_FIFO -- requirements
Module: rx_fifo

---
 rtl/rx_pkg.sv | 21 ++
 rtl/rx_fifo_mem.sv | 24 ++
 rtl/rx_fifo.sv | 134 +++++++++++++
 tb/tb_rx_fifo.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rx_pkg.sv
// Shared definitions for the receive FIFO: processor port map, status bit
// positions and the stored entry layout.
package rx_pkg;

  localparam logic [3:0] RX_DATA_PORT = 4'h0;
  localparam logic [3:0] RX_STAT_PORT = 4'h1;
  localparam logic [3:0] RX_LVL_PORT  = 4'h2;

  localparam int unsigned RDY  = 0;
  localparam int unsigned FULL = 1;
  localparam int unsigned PERR = 2;
  localparam int unsigned FERR = 3;
  localparam int unsigned OVF  = 4;

  typedef struct packed {
    logic       ferr;
    logic       perr;
    logic [7:0] data;
  } rx_entry_t;

endpackage

// File: rtl/rx_fifo_mem.sv
// Entry storage for rx_fifo: synchronous write, asynchronous read, no reset.
module rx_fifo_mem
  import rx_pkg::*;
#(
  parameter  int unsigned DEPTH = 16,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  rx_entry_t     wr_data,
  input  logic [AW-1:0] rd_addr,
  output rx_entry_t     rd_data
);

  rx_entry_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/rx_fifo.sv
// Receive FIFO with processor port interface and first-word fall-through reads.
// Define RX_FIFO_IRQ_EN to build the registered level/overflow interrupt.
module rx_fifo
  import rx_pkg::*;
#(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned THRESH = 8
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       WR_STB,
  input  logic [7:0] WR_DATA,
  input  logic       WR_PERR,
  input  logic       WR_FERR,
  input  logic [3:0] port_id,
  input  logic       read_strobe,
  output logic [7:0] PORT_DATA,
  output logic       RX_RDY,
  output logic       IRQ
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  if (DEPTH < 4 || DEPTH > 64 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("rx_fifo: DEPTH must be a power of two in 4..64");
  end
  if (THRESH == 0 || THRESH > DEPTH) begin : g_bad_thresh
    $error("rx_fifo: THRESH must be in 1..DEPTH");
  end

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] level;
  logic [LW-1:0] level_next;
  logic          ovf;
  logic          ovf_next;
  logic          empty;
  logic          full;
  logic          pop;
  logic          push;
  logic          overflow;
  logic [7:0]    status;
  rx_entry_t     head;
  rx_entry_t     wr_entry;

  assign empty    = (level == '0);
  assign full     = (level == LW'(DEPTH));
  assign RX_RDY   = !empty;
  assign wr_entry = {WR_FERR, WR_PERR, WR_DATA};

  rx_fifo_mem #(.DEPTH(DEPTH)) u_mem (
    .clk     (CLK),
    .wr_en   (push),
    .wr_addr (wr_ptr),
    .wr_data (wr_entry),
    .rd_addr (rd_ptr),
    .rd_data (head)
  );

  // A pop frees the slot being written, so a full FIFO still accepts a write that coincides with a pop.
  always_comb begin
    pop        = 1'b0;
    push       = 1'b0;
    overflow   = 1'b0;
    level_next = level;
    ovf_next   = ovf;

    pop      = read_strobe && (port_id == RX_DATA_PORT) && !empty;
    push     = WR_STB && (!full || pop);
    overflow = WR_STB && full && !pop;

    case ({push, pop})
      2'b10:   level_next = level + LW'(1);
      2'b01:   level_next = level - LW'(1);
      default: level_next = level;
    endcase

    if (overflow) begin
      ovf_next = 1'b1;
    end else if (read_strobe && (port_id == RX_STAT_PORT)) begin
      ovf_next = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      level <= level_next;
      ovf   <= ovf_next;
    end
  end

  // Head fields are masked while empty since the storage is never cleared.
  always_comb begin
    status       = 8'h00;
    status[RDY]  = !empty;
    status[FULL] = full;
    status[PERR] = !empty && head.perr;
    status[FERR] = !empty && head.ferr;
    status[OVF]  = ovf;

    PORT_DATA = 8'h00;
    case (port_id)
      RX_DATA_PORT: PORT_DATA = empty ? 8'h00 : head.data;
      RX_STAT_PORT: PORT_DATA = status;
      RX_LVL_PORT:  PORT_DATA = 8'(level);
      default:      PORT_DATA = 8'h00;
    endcase
  end

`ifdef RX_FIFO_IRQ_EN
  logic irq_q;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= (level_next >= LW'(THRESH)) || ovf_next;
    end
  end

  assign IRQ = irq_q;
`else
  assign IRQ = 1'b0;
`endif

endmodule

// File: tb/tb_rx_fifo.sv
// Self-checking bench for rx_fifo: directed vector table, corner-case
// sequences and randomized traffic against a queue-based reference model.
module tb_rx_fifo;

  localparam int unsigned DEPTH  = 16;
  localparam int unsigned THRESH = 8;

  logic       CLK = 1'b0;
  logic       RESET = 1'b0;
  logic       WR_STB = 1'b0;
  logic [7:0] WR_DATA = 8'h00;
  logic       WR_PERR = 1'b0;
  logic       WR_FERR = 1'b0;
  logic [3:0] port_id = 4'h0;
  logic       read_strobe = 1'b0;
  logic [7:0] PORT_DATA;
  logic       RX_RDY;
  logic       IRQ;

  int errors = 0;
  int checks = 0;

  rx_fifo #(.DEPTH(DEPTH), .THRESH(THRESH)) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .WR_STB      (WR_STB),
    .WR_DATA     (WR_DATA),
    .WR_PERR     (WR_PERR),
    .WR_FERR     (WR_FERR),
    .port_id     (port_id),
    .read_strobe (read_strobe),
    .PORT_DATA   (PORT_DATA),
    .RX_RDY      (RX_RDY),
    .IRQ         (IRQ)
  );

  always #10 CLK = ~CLK;

  // Reference model: queue of {ferr, perr, data} plus sticky overflow and irq.
  logic [9:0] q[$];
  logic       m_ovf = 1'b0;
  logic       m_irq = 1'b0;

  function automatic logic [7:0] exp_port(input logic [3:0] p);
    logic [7:0] v;
    v = 8'h00;
    if (p == 4'h0) begin
      if (q.size() != 0) v = q[0][7:0];
    end else if (p == 4'h1) begin
      v[0] = (q.size() != 0);
      v[1] = (q.size() == DEPTH);
      if (q.size() != 0) begin
        v[2] = q[0][8];
        v[3] = q[0][9];
      end
      v[4] = m_ovf;
    end else if (p == 4'h2) begin
      v = 8'(q.size());
    end
    return v;
  endfunction

  task automatic model_step(input logic wr, input logic [7:0] d, input logic pe, input logic fe,
                            input logic rs, input logic [3:0] pid);
    logic do_pop;
    logic ovfl;
    do_pop = rs && (pid == 4'h0) && (q.size() != 0);
    ovfl   = wr && (q.size() == DEPTH) && !do_pop;
    if (do_pop) void'(q.pop_front());
    if (wr && !ovfl) q.push_back({fe, pe, d});
    if (ovfl) m_ovf = 1'b1;
    else if (rs && pid == 4'h1) m_ovf = 1'b0;
`ifdef RX_FIFO_IRQ_EN
    m_irq = (q.size() >= THRESH) || m_ovf;
`else
    m_irq = 1'b0;
`endif
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic peek(input logic [3:0] p, output logic [7:0] v);
    port_id = p;
    #1;
    v = PORT_DATA;
  endtask

  task automatic check_all(input string tag);
    logic [7:0] v;
    peek(4'h0, v); chk({tag, "_p0"}, v, exp_port(4'h0));
    peek(4'h1, v); chk({tag, "_p1"}, v, exp_port(4'h1));
    peek(4'h2, v); chk({tag, "_p2"}, v, exp_port(4'h2));
    peek(4'hB, v); chk({tag, "_unmapped"}, v, 8'h00);
    chk({tag, "_rdy"}, {7'b0, RX_RDY}, {7'b0, (q.size() != 0)});
    chk({tag, "_irq"}, {7'b0, IRQ}, {7'b0, m_irq});
  endtask

  task automatic cycle(input logic wr, input logic [7:0] d, input logic pe, input logic fe,
                       input logic rs, input logic [3:0] pid);
    @(negedge CLK);
    WR_STB = wr; WR_DATA = d; WR_PERR = pe; WR_FERR = fe;
    read_strobe = rs; port_id = pid;
    @(posedge CLK);
    model_step(wr, d, pe, fe, rs, pid);
    #1;
    WR_STB = 1'b0;
    read_strobe = 1'b0;
  endtask

  task automatic wr_byte(input logic [7:0] d);
    cycle(1'b1, d, 1'b0, 1'b0, 1'b0, 4'h0);
  endtask

  task automatic pop_byte();
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 4'h0);
  endtask

  // Asserts reset between edges, checks the immediate clear, releases at a falling edge.
  task automatic do_reset(input string tag);
    logic [7:0] v;
    @(negedge CLK);
    #1;
    RESET = 1'b0;
    WR_STB = 1'b0;
    read_strobe = 1'b0;
    #1;
    q.delete();
    m_ovf = 1'b0;
    m_irq = 1'b0;
    chk({tag, "_rst_rdy"}, {7'b0, RX_RDY}, 8'h00);
    chk({tag, "_rst_irq"}, {7'b0, IRQ}, 8'h00);
    peek(4'h0, v); chk({tag, "_rst_p0"}, v, 8'h00);
    peek(4'h1, v); chk({tag, "_rst_p1"}, v, 8'h00);
    peek(4'h2, v); chk({tag, "_rst_p2"}, v, 8'h00);
    @(negedge CLK);
    RESET = 1'b1;
  endtask

  typedef struct {
    logic       wr;
    logic [7:0] d;
    logic       pe;
    logic       fe;
    logic       rs;
    logic [3:0] pid;
    logic       rdy;
    logic [7:0] p0;
    logic [7:0] p1;
    logic [7:0] p2;
  } vec_t;

  vec_t tbl[10];

  initial begin
    logic [7:0] v;
    logic [3:0] pids[5];
    logic       lw;
    logic [7:0] ld;

    tbl[0] = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 8'hA5, 8'h01, 8'h01};
    tbl[1] = '{1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 8'hA5, 8'h01, 8'h02};
    tbl[2] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 4'h0, 1'b1, 8'h3C, 8'h01, 8'h01};
    tbl[3] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 4'h0, 1'b0, 8'h00, 8'h00, 8'h00};
    tbl[4] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 4'h0, 1'b0, 8'h00, 8'h00, 8'h00};
    tbl[5] = '{1'b1, 8'h55, 1'b1, 1'b1, 1'b0, 4'h0, 1'b1, 8'h55, 8'h0D, 8'h01};
    tbl[6] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 4'h1, 1'b1, 8'h55, 8'h0D, 8'h01};
    tbl[7] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 4'h5, 1'b1, 8'h55, 8'h0D, 8'h01};
    tbl[8] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 4'h2, 1'b1, 8'h55, 8'h0D, 8'h01};
    tbl[9] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 4'h0, 1'b0, 8'h00, 8'h00, 8'h00};

    // Power-on reset
    repeat (2) @(negedge CLK);
    check_all("por");
    RESET = 1'b1;

    // Directed vector table
    for (int i = 0; i < 10; i++) begin
      cycle(tbl[i].wr, tbl[i].d, tbl[i].pe, tbl[i].fe, tbl[i].rs, tbl[i].pid);
      chk($sformatf("tbl%0d_rdy", i), {7'b0, RX_RDY}, {7'b0, tbl[i].rdy});
      peek(4'h0, v); chk($sformatf("tbl%0d_p0", i), v, tbl[i].p0);
      peek(4'h1, v); chk($sformatf("tbl%0d_p1", i), v, tbl[i].p1);
      peek(4'h2, v); chk($sformatf("tbl%0d_p2", i), v, tbl[i].p2);
    end

    // Overflow: 17 writes into 16 entries, then drain in order
    do_reset("ovf");
    for (int i = 0; i < 17; i++) wr_byte(8'(i));
    peek(4'h1, v); chk("ovf_status", v, 8'h13);
    peek(4'h2, v); chk("ovf_level", v, 8'h10);
    check_all("ovf_full");
    for (int i = 0; i < 16; i++) begin
      peek(4'h0, v); chk($sformatf("ovf_order%0d", i), v, 8'(i));
      pop_byte();
    end
    peek(4'h0, v); chk("ovf_drained_p0", v, 8'h00);
    peek(4'h1, v); chk("ovf_sticky", v, 8'h10);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 4'h1);
    peek(4'h1, v); chk("ovf_cleared", v, 8'h00);

    // Full FIFO with simultaneous write and pop
    do_reset("fullwp");
    for (int i = 0; i < 16; i++) wr_byte(8'(i));
    cycle(1'b1, 8'hEE, 1'b0, 1'b0, 1'b1, 4'h0);
    peek(4'h2, v); chk("fullwp_level", v, 8'h10);
    peek(4'h1, v); chk("fullwp_status", v, 8'h03);
    check_all("fullwp");
    for (int i = 1; i < 16; i++) pop_byte();
    peek(4'h0, v); chk("fullwp_last", v, 8'hEE);
    pop_byte();
    check_all("fullwp_empty");

    // Empty FIFO with simultaneous write and pop
    cycle(1'b1, 8'h42, 1'b0, 1'b0, 1'b1, 4'h0);
    peek(4'h2, v); chk("emptywp_level", v, 8'h01);
    peek(4'h0, v); chk("emptywp_head", v, 8'h42);

    // Overflow and status clear in the same cycle: overflow wins
    for (int i = 0; i < 15; i++) wr_byte(8'h80 + 8'(i));
    cycle(1'b1, 8'hFF, 1'b0, 1'b0, 1'b1, 4'h1);
    peek(4'h1, v); chk("ovf_wins", v, 8'h13);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 4'h1);
    peek(4'h1, v); chk("ovf_clear_full", v, 8'h03);
    check_all("ovf_clear_full");

    // Mid-operation reset, then a write on the first edge after release
    do_reset("mid");
    for (int i = 0; i < 5; i++) wr_byte(8'h10 + 8'(i));
    peek(4'h2, v); chk("mid_level5", v, 8'h05);
    do_reset("mid5");
    WR_STB = 1'b1; WR_DATA = 8'h77; WR_PERR = 1'b0; WR_FERR = 1'b0;
    @(posedge CLK);
    model_step(1'b1, 8'h77, 1'b0, 1'b0, 1'b0, 4'h0);
    #1;
    WR_STB = 1'b0;
    peek(4'h0, v); chk("first_edge_wr", v, 8'h77);
    check_all("first_edge");

    // Threshold interrupt
    do_reset("irq");
    for (int i = 0; i < 7; i++) wr_byte(8'(i));
    chk("irq_below", {7'b0, IRQ}, 8'h00);
    wr_byte(8'h07);
`ifdef RX_FIFO_IRQ_EN
    chk("irq_at_thresh", {7'b0, IRQ}, 8'h01);
`else
    chk("irq_at_thresh", {7'b0, IRQ}, 8'h00);
`endif
    pop_byte();
    chk("irq_after_pop", {7'b0, IRQ}, 8'h00);
    check_all("irq");

    // Randomized traffic against the reference model
    do_reset("rnd");
    pids[0] = 4'h0; pids[1] = 4'h0; pids[2] = 4'h1; pids[3] = 4'h2; pids[4] = 4'h9;
    for (int i = 0; i < 400; i++) begin
      lw = ($urandom_range(0, 99) < 55);
      ld = 8'($urandom);
      cycle(lw, ld, 1'($urandom), 1'($urandom), 1'($urandom), pids[$urandom_range(0, 4)]);
      check_all($sformatf("rnd%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
